alu_operand_stage: RTL and testbench

- Issue stage directly upstream of the ALU.
- Accepts 32-bit instruction words over a valid/ready handshake and decodes the opcode, MUXsel and register fields.
- Reads a 16x32 register file, or selects an immediate, and presents registered ALUopsel/MUXsel/operandA/operandB plus a destination tag to the ALU.
- Holds a scoreboard of busy registers so that no instruction issues before its sources have been written back.

---
 rtl/alu_operand_stage_if.sv | 28 ++
 rtl/alu_operand_stage.sv | 150 +++++++++++++++
 tb/tb_alu_operand_stage.sv | 211 +++++++++++++++++++++
 3 files changed

// File: rtl/alu_operand_stage_if.sv
// Bundle of issue-side, ALU-side and writeback signals for alu_operand_stage.
// slave  : seen from the operand stage itself.
// master : seen from the environment (fetch / ALU / writeback).
interface alu_operand_stage_if;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr;
  logic        out_valid;
  logic        out_ready;
  logic [3:0]  ALUopsel;
  logic        MUXsel;
  logic [31:0] operandA;
  logic [31:0] operandB;
  logic [3:0]  dest;
  logic        wb_en;
  logic [3:0]  wb_addr;
  logic [31:0] wb_data;

  modport slave (
    input  instr_valid, instr, out_ready, wb_en, wb_addr, wb_data,
    output instr_ready, out_valid, ALUopsel, MUXsel, operandA, operandB, dest
  );

  modport master (
    output instr_valid, instr, out_ready, wb_en, wb_addr, wb_data,
    input  instr_ready, out_valid, ALUopsel, MUXsel, operandA, operandB, dest
  );
endinterface

// File: rtl/alu_operand_stage.sv
// Issue stage in front of the ALU: decodes an instruction word, reads the
// register file (or extends the immediate), tracks busy destinations in a
// scoreboard and holds one registered operand bundle for the ALU.
// Optional macro ALU_WB_BYPASS_EN: forwards the in-flight writeback into the
// operand read and releases hazards on the register being written back.
module alu_operand_stage #(
  parameter int NREGS      = 16,
  parameter bit IMM_SIGNED = 1'b1
) (
  input  logic                clk,
  input  logic                reset,
  alu_operand_stage_if.slave  bus
);

  typedef enum logic {S_EMPTY, S_FULL} state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [NREGS-1:0]   r_busy;
  logic [31:0]        r_rf [NREGS];
  logic [3:0]         r_alu_op;
  logic               r_mux_sel;
  logic [31:0]        r_opa;
  logic [31:0]        r_opb;
  logic [3:0]         r_dest;

  // Instruction fields
  logic [3:0]  w_op;
  logic        w_mux;
  logic        w_imm_sel;
  logic [3:0]  w_rd;
  logic [3:0]  w_rs1;
  logic [3:0]  w_rs2;
  logic [15:0] w_imm16;
  logic        w_uses_b;
  logic        w_writes;
  logic        w_wb_act;
  logic        w_byp_rs1;
  logic        w_byp_rs2;
  logic        w_byp_rd;
  logic        w_hazard;
  logic        w_ready;
  logic        w_accept;
  logic [31:0] w_opa;
  logic [31:0] w_opb;

  function automatic logic [31:0] ext_imm(input logic [15:0] imm);
    if (IMM_SIGNED) ext_imm = {{16{imm[15]}}, imm};
    else            ext_imm = {16'b0, imm};
  endfunction

  assign w_op      = bus.instr[31:28];
  assign w_mux     = bus.instr[27];
  assign w_imm_sel = bus.instr[26];
  assign w_rd      = bus.instr[25:22];
  assign w_rs1     = bus.instr[21:18];
  assign w_rs2     = bus.instr[17:14];
  assign w_imm16   = bus.instr[15:0];

  assign w_uses_b  = !w_imm_sel;
  assign w_writes  = (w_op != 4'b0000) && (w_rd != 4'd0);
  // r0 writebacks are architecturally dropped, so they never count as activity
  assign w_wb_act  = bus.wb_en && (bus.wb_addr != 4'd0);

`ifdef ALU_WB_BYPASS_EN
  assign w_byp_rs1 = w_wb_act && (bus.wb_addr == w_rs1);
  assign w_byp_rs2 = w_wb_act && (bus.wb_addr == w_rs2);
  assign w_byp_rd  = w_wb_act && (bus.wb_addr == w_rd);
`else
  assign w_byp_rs1 = 1'b0;
  assign w_byp_rs2 = 1'b0;
  assign w_byp_rd  = 1'b0;
`endif

  // busy[0] can never be set, so r0 sources never stall
  assign w_hazard = (r_busy[w_rs1] && !w_byp_rs1)
                 || (w_uses_b && r_busy[w_rs2] && !w_byp_rs2)
                 || (w_writes && r_busy[w_rd]  && !w_byp_rd);

  assign w_ready  = ((r_state == S_EMPTY) || bus.out_ready) && !w_hazard;
  assign w_accept = bus.instr_valid && w_ready;

  assign w_opa = w_byp_rs1       ? bus.wb_data :
                 (w_rs1 == 4'd0) ? 32'd0       : r_rf[w_rs1];
  assign w_opb = w_imm_sel       ? ext_imm(w_imm16) :
                 w_byp_rs2       ? bus.wb_data      :
                 (w_rs2 == 4'd0) ? 32'd0            : r_rf[w_rs2];

  // Output slot state register
  always_ff @(posedge clk) begin
    if (reset) r_state <= S_EMPTY;
    else       r_state <= w_state_nxt;
  end

  // Slot next state: accept fills (or refills) it, a consume with no accept drains it
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_EMPTY: if (w_accept) w_state_nxt = S_FULL;
      S_FULL:  if (w_accept) w_state_nxt = S_FULL;
               else if (bus.out_ready) w_state_nxt = S_EMPTY;
      default: w_state_nxt = S_EMPTY;
    endcase
  end

  // Operand bundle capture on accept; held otherwise
  always_ff @(posedge clk) begin
    if (reset) begin
      r_alu_op  <= 4'd0;
      r_mux_sel <= 1'b0;
      r_opa     <= 32'd0;
      r_opb     <= 32'd0;
      r_dest    <= 4'd0;
    end else if (w_accept) begin
      r_alu_op  <= w_op;
      r_mux_sel <= w_mux;
      r_opa     <= w_opa;
      r_opb     <= w_opb;
      r_dest    <= w_rd;
    end
  end

  // Scoreboard: writeback clears, a writing accept sets; set is ordered last so it wins
  always_ff @(posedge clk) begin
    if (reset) begin
      r_busy <= '0;
    end else begin
      if (w_wb_act)             r_busy[bus.wb_addr] <= 1'b0;
      if (w_accept && w_writes) r_busy[w_rd]        <= 1'b1;
    end
  end

  // Register file writeback
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NREGS; i++) r_rf[i] <= 32'd0;
    end else if (w_wb_act) begin
      r_rf[bus.wb_addr] <= bus.wb_data;
    end
  end

  assign bus.instr_ready = w_ready;
  assign bus.out_valid   = (r_state == S_FULL);
  assign bus.ALUopsel    = r_alu_op;
  assign bus.MUXsel      = r_mux_sel;
  assign bus.operandA    = r_opa;
  assign bus.operandB    = r_opb;
  assign bus.dest        = r_dest;

endmodule

// File: tb/tb_alu_operand_stage.sv
// Directed bench for alu_operand_stage (default parameters, IMM_SIGNED=1).
// Inputs change on the falling edge; outputs are checked on the falling edge.
module tb_alu_operand_stage;

  logic clk;
  logic reset;
  int   checks;
  int   errors;

  alu_operand_stage_if bus ();

  alu_operand_stage dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] enc_r(input logic [3:0] op, input logic [3:0] rd,
                                        input logic [3:0] rs1, input logic [3:0] rs2);
    enc_r = {op, 1'b0, 1'b0, rd, rs1, rs2, 14'b0};
  endfunction

  function automatic logic [31:0] enc_i(input logic [3:0] op, input logic mux,
                                        input logic [3:0] rd, input logic [3:0] rs1,
                                        input logic [15:0] imm);
    enc_i = {op, mux, 1'b1, rd, rs1, 2'b00, imm};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(negedge clk);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    checks = 0;
    errors = 0;
    reset           = 1'b1;
    bus.instr_valid = 1'b0;
    bus.instr       = 32'd0;
    bus.out_ready   = 1'b1;
    bus.wb_en       = 1'b0;
    bus.wb_addr     = 4'd0;
    bus.wb_data     = 32'd0;
    cyc();
    cyc();
    reset = 1'b0;
    #1;
    // reset state
    chk("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
    chk("rst_ready",     {31'd0, bus.instr_ready}, 32'd1);
    chk("rst_aluop",     {28'd0, bus.ALUopsel}, 32'd0);
    chk("rst_mux",       {31'd0, bus.MUXsel}, 32'd0);
    chk("rst_opa",       bus.operandA, 32'd0);
    chk("rst_opb",       bus.operandB, 32'd0);
    chk("rst_dest",      {28'd0, bus.dest}, 32'd0);

    // immediate issue, sign extension of 0xFFFF
    bus.instr       = enc_i(4'h1, 1'b1, 4'd1, 4'd0, 16'hFFFF);
    bus.instr_valid = 1'b1;
    #1 chk("imm_ready", {31'd0, bus.instr_ready}, 32'd1);
    cyc();
    bus.instr_valid = 1'b0;
    chk("imm_valid", {31'd0, bus.out_valid}, 32'd1);
    chk("imm_opa",   bus.operandA, 32'd0);
    chk("imm_opb",   bus.operandB, 32'hFFFF_FFFF);
    chk("imm_dest",  {28'd0, bus.dest}, 32'd1);
    chk("imm_op",    {28'd0, bus.ALUopsel}, 32'd1);
    chk("imm_mux",   {31'd0, bus.MUXsel}, 32'd1);

    // preload r1=5, r2=7
    bus.wb_en = 1'b1; bus.wb_addr = 4'd1; bus.wb_data = 32'd5;
    cyc();
    bus.wb_addr = 4'd2; bus.wb_data = 32'd7;
    cyc();
    bus.wb_en = 1'b0;
    chk("drain_valid", {31'd0, bus.out_valid}, 32'd0);

    // back-to-back independent ADD / XOR
    bus.instr       = enc_r(4'h2, 4'd3, 4'd1, 4'd2);
    bus.instr_valid = 1'b1;
    #1 chk("b2b_ready0", {31'd0, bus.instr_ready}, 32'd1);
    cyc();
    bus.instr = enc_r(4'h3, 4'd4, 4'd1, 4'd2);
    #1 chk("b2b_ready1", {31'd0, bus.instr_ready}, 32'd1);
    chk("add_opa",  bus.operandA, 32'd5);
    chk("add_opb",  bus.operandB, 32'd7);
    chk("add_dest", {28'd0, bus.dest}, 32'd3);
    chk("add_op",   {28'd0, bus.ALUopsel}, 32'd2);
    cyc();
    bus.instr_valid = 1'b0;
    chk("xor_valid", {31'd0, bus.out_valid}, 32'd1);
    chk("xor_opa",   bus.operandA, 32'd5);
    chk("xor_opb",   bus.operandB, 32'd7);
    chk("xor_dest",  {28'd0, bus.dest}, 32'd4);
    chk("xor_op",    {28'd0, bus.ALUopsel}, 32'd3);
    // busy[3], busy[4] probed through instr_ready; r5 is free
    bus.instr = enc_r(4'h1, 4'd0, 4'd3, 4'd0);
    #1 chk("busy3_probe", {31'd0, bus.instr_ready}, 32'd0);
    bus.instr = enc_r(4'h1, 4'd0, 4'd4, 4'd0);
    #1 chk("busy4_probe", {31'd0, bus.instr_ready}, 32'd0);
    bus.instr = enc_r(4'h1, 4'd0, 4'd5, 4'd0);
    #1 chk("free5_probe", {31'd0, bus.instr_ready}, 32'd1);
    cyc();

    // RAW stall on r3
    bus.instr       = enc_r(4'h5, 4'd6, 4'd3, 4'd0);
    bus.instr_valid = 1'b1;
    #1 chk("raw_stall0", {31'd0, bus.instr_ready}, 32'd0);
    cyc();
    chk("raw_empty", {31'd0, bus.out_valid}, 32'd0);
    chk("raw_stall1", {31'd0, bus.instr_ready}, 32'd0);
    bus.wb_en = 1'b1; bus.wb_addr = 4'd3; bus.wb_data = 32'h12;
`ifdef ALU_WB_BYPASS_EN
    #1 chk("raw_wb_ready", {31'd0, bus.instr_ready}, 32'd1);
    cyc();
    bus.wb_en = 1'b0;
    bus.instr_valid = 1'b0;
`else
    #1 chk("raw_wb_ready", {31'd0, bus.instr_ready}, 32'd0);
    cyc();
    bus.wb_en = 1'b0;
    #1 chk("raw_next_ready", {31'd0, bus.instr_ready}, 32'd1);
    cyc();
    bus.instr_valid = 1'b0;
`endif
    chk("raw_opa",  bus.operandA, 32'h12);
    chk("raw_dest", {28'd0, bus.dest}, 32'd6);

    // backpressure: hold three cycles while FULL
    bus.out_ready   = 1'b0;
    bus.instr       = enc_r(4'h7, 4'd7, 4'd1, 4'd2);
    bus.instr_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("bp_ready", {31'd0, bus.instr_ready}, 32'd0);
      chk("bp_valid", {31'd0, bus.out_valid}, 32'd1);
      chk("bp_dest",  {28'd0, bus.dest}, 32'd6);
      chk("bp_opa",   bus.operandA, 32'h12);
      cyc();
    end
    bus.out_ready = 1'b1;
    #1 chk("bp_release_ready", {31'd0, bus.instr_ready}, 32'd1);
    cyc();
    bus.instr_valid = 1'b0;
    chk("bp_new_dest", {28'd0, bus.dest}, 32'd7);
    chk("bp_new_opa",  bus.operandA, 32'd5);
    chk("bp_new_opb",  bus.operandB, 32'd7);

    // set/clear collision on r5
    bus.instr       = enc_r(4'h1, 4'd5, 4'd1, 4'd2);
    bus.instr_valid = 1'b1;
    bus.wb_en = 1'b1; bus.wb_addr = 4'd5; bus.wb_data = 32'd33;
    #1 chk("coll_ready", {31'd0, bus.instr_ready}, 32'd1);
    cyc();
    bus.instr_valid = 1'b0;
    bus.wb_en       = 1'b0;
    chk("coll_dest", {28'd0, bus.dest}, 32'd5);
    bus.instr = enc_r(4'h1, 4'd0, 4'd5, 4'd0);
    #1 chk("coll_busy5", {31'd0, bus.instr_ready}, 32'd0);

    // r0 writes ignored, r0 reads zero
    bus.instr       = enc_r(4'h1, 4'd8, 4'd0, 4'd1);
    bus.instr_valid = 1'b1;
    bus.wb_en = 1'b1; bus.wb_addr = 4'd0; bus.wb_data = 32'd99;
    cyc();
    bus.wb_en = 1'b0;
    bus.instr = enc_r(4'h1, 4'd9, 4'd0, 4'd2);
    cyc();
    bus.instr_valid = 1'b0;
    chk("r0_opa", bus.operandA, 32'd0);
    chk("r0_opb", bus.operandB, 32'd7);

    // mid-operation reset while FULL with busy bits set
    bus.out_ready = 1'b0;
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    bus.out_ready = 1'b1;
    chk("mrst_valid", {31'd0, bus.out_valid}, 32'd0);
    chk("mrst_dest",  {28'd0, bus.dest}, 32'd0);
    chk("mrst_opa",   bus.operandA, 32'd0);
    bus.instr = enc_r(4'h1, 4'd0, 4'd5, 4'd0);
    #1 chk("mrst_busy5", {31'd0, bus.instr_ready}, 32'd1);
    bus.instr       = enc_r(4'h1, 4'd2, 4'd1, 4'd1);
    bus.instr_valid = 1'b1;
    cyc();
    bus.instr_valid = 1'b0;
    chk("mrst_r1", bus.operandA, 32'd0);
    chk("mrst_issue_valid", {31'd0, bus.out_valid}, 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
